// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and defaults for the UART receive path.
//   rx_state_t           : receiver FSM state encoding
//   DEF_CLKS_PER_BIT     : default clock cycles per UART bit
//   DEF_DATA_WIDTH       : default payload bits per frame
//   even_parity_mismatch : helper comparing a received parity bit to a byte
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_WIDTH   = 8;

    // Even parity: the transmitted parity bit equals the XOR of the payload.
    function automatic logic even_parity_mismatch(input logic [DEF_DATA_WIDTH-1:0] data,
                                                  input logic                      par_bit);
        return par_bit ^ (^data);
    endfunction

endpackage

// File: rtl/uart_rx_pusher_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for asynchronous inputs. The reset value is a
// parameter so idle-high lines (such as a UART rx) come out of reset at their
// idle level and do not look like an edge.
// Ports:
//   clock : destination clock, rising edge
//   reset : asynchronous, active-high
//   d     : asynchronous input
//   q     : synchronised output, two clocks of latency
// ----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_pusher.sv
// ----------------------------------------------------------------------------
// uart_rx_pusher
// UART receiver (8N1, optionally 8E1) that feeds a ring buffer directly: each
// good frame yields a one-cycle push with the byte on datain. Bad frames are
// dropped and reported with a one-cycle error pulse instead.
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-high
//   enable       : receiver enable; low holds IDLE and aborts any frame
//   rx           : asynchronous serial line, idle high
//   push         : one-cycle strobe, datain valid while high
//   datain       : received byte, LSB first on the line; held between frames
//   frame_error  : one-cycle pulse, stop bit sampled low
//   parity_error : one-cycle pulse, parity mismatch (PARITY_EN=1 only)
//   busy         : high whenever the FSM is not IDLE
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | wait half a bit, confirm start bit still low (glitch filter)
// DATA      | sample one payload bit per bit time, LSB first
// PARITY    | sample even-parity bit and record a mismatch
// STOP      | sample stop bit, emit push or an error pulse
// WAIT_IDLE | stop bit was low; wait for the line to return high (break)
// ----------------------------------------------------------------------------
module uart_rx_pusher
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  rx,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] datain,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    logic                  rx_s;
    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    // Set once rx_s has been seen high since enable went high, so a line that
    // is already low when enable rises is not mistaken for a start bit.
    logic                  armed;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            par_bad      <= 1'b0;
            armed        <= 1'b0;
            push         <= 1'b0;
            datain       <= '0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            busy         <= 1'b0;
        end else begin
            push         <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;

            if (!enable) begin
                state   <= IDLE;
                cnt     <= '0;
                idx     <= '0;
                par_bad <= 1'b0;
                armed   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt     <= '0;
                        idx     <= '0;
                        par_bad <= 1'b0;
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= START;
                            busy  <= 1'b1;
                        end
                    end

                    START: begin
                        if (cnt == HALF_TC) begin
                            cnt <= '0;
                            idx <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (cnt == BIT_TC) begin
                            cnt        <= '0;
                            shreg[idx] <= rx_s;
                            if (idx == IDX_LAST) begin
                                idx   <= '0;
                                state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    PARITY: begin
                        if (cnt == BIT_TC) begin
                            cnt     <= '0;
                            par_bad <= rx_s ^ (^shreg);
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    STOP: begin
                        if (cnt == BIT_TC) begin
                            cnt <= '0;
                            if (rx_s) begin
                                // Leaving here mid stop bit lets a start bit
                                // that follows with no gap be caught.
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (par_bad) begin
                                    parity_error <= 1'b1;
                                end else begin
                                    push   <= 1'b1;
                                    datain <= shreg;
                                end
                            end else begin
                                frame_error <= 1'b1;
                                state       <= WAIT_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    WAIT_IDLE: begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            armed <= 1'b1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
